// File: rtl/watch_time_set.sv
// User time-setting front end: synchronises and debounces four switches, steps a
// set-mode FSM over hour/minute/second BCD fields and strobes the new time out.
module watch_time_set #(
  parameter int DEBOUNCE_CNT = 250000,
  parameter int CNT_W        = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  input  logic [3:0] sec_1,
  input  logic [2:0] sec_10,
  input  logic [3:0] min_1,
  input  logic [2:0] min_10,
  input  logic [3:0] hour_1,
  input  logic [1:0] hour_10,
  output logic [3:0] set_sec_1,
  output logic [2:0] set_sec_10,
  output logic [3:0] set_min_1,
  output logic [2:0] set_min_10,
  output logic [3:0] set_hour_1,
  output logic [1:0] set_hour_10,
  output logic       load,
  output logic       run_en,
  output logic [1:0] set_mode
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

  state_t           state;
  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       db_lvl;
  logic [3:0]       press_p2;
  logic [CNT_W-1:0] db_cnt [4];

  logic mode_pr, up_pr, dn_pr, cf_pr;
  assign mode_pr = press_p2[0];
  assign up_pr   = press_p2[1];
  assign dn_pr   = press_p2[2];
  assign cf_pr   = press_p2[3];

  assign set_mode = state;

  // Hours run 00..23; result packed as {tens[1:0], units[3:0]}.
  function automatic logic [5:0] hour_step(input logic [1:0] h10, input logic [3:0] h1,
                                           input logic up);
    logic [5:0] r;
    if (up) begin
      if (h10 >= 2'd2 && h1 >= 4'd3) r = {2'd0, 4'd0};
      else if (h1 >= 4'd9)           r = {h10 + 2'd1, 4'd0};
      else                           r = {h10, h1 + 4'd1};
    end else begin
      if (h10 == 2'd0 && h1 == 4'd0) r = {2'd2, 4'd3};
      else if (h1 == 4'd0)           r = {h10 - 2'd1, 4'd9};
      else                           r = {h10, h1 - 4'd1};
    end
    return r;
  endfunction

  // Minutes and seconds run 00..59; result packed as {tens[2:0], units[3:0]}.
  function automatic logic [6:0] ms_step(input logic [2:0] t10, input logic [3:0] u1,
                                         input logic up);
    logic [6:0] r;
    if (up) begin
      if (t10 >= 3'd5 && u1 >= 4'd9) r = {3'd0, 4'd0};
      else if (u1 >= 4'd9)           r = {t10 + 3'd1, 4'd0};
      else                           r = {t10, u1 + 4'd1};
    end else begin
      if (t10 == 3'd0 && u1 == 4'd0) r = {3'd5, 4'd9};
      else if (u1 == 4'd0)           r = {t10 - 3'd1, 4'd9};
      else                           r = {t10, u1 - 4'd1};
    end
    return r;
  endfunction

  // Stage p0/p1: two-flop synchroniser per switch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce; a press pulse fires only when the accepted level rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_lvl   <= '0;
      press_p2 <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        press_p2[i] <= 1'b0;
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          db_lvl[i]   <= sync_p1[i];
          db_cnt[i]   <= '0;
          press_p2[i] <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage p3: set-mode FSM and edit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      run_en      <= 1'b1;
      load        <= 1'b0;
      set_sec_1   <= '0;
      set_sec_10  <= '0;
      set_min_1   <= '0;
      set_min_10  <= '0;
      set_hour_1  <= '0;
      set_hour_10 <= '0;
    end else begin
      load <= 1'b0;
      if (state == RUN) begin
        if (mode_pr) begin
          set_sec_1   <= sec_1;
          set_sec_10  <= sec_10;
          set_min_1   <= min_1;
          set_min_10  <= min_10;
          set_hour_1  <= hour_1;
          set_hour_10 <= hour_10;
          state       <= SET_HOUR;
          run_en      <= 1'b0;
        end
      end else if (cf_pr || (mode_pr && state == SET_SEC)) begin
        state  <= RUN;
        run_en <= 1'b1;
        load   <= 1'b1;
      end else if (mode_pr) begin
        state <= (state == SET_HOUR) ? SET_MIN : SET_SEC;
      end else if (up_pr ^ dn_pr) begin
        case (state)
          SET_HOUR: {set_hour_10, set_hour_1} <= hour_step(set_hour_10, set_hour_1, up_pr);
          SET_MIN:  {set_min_10, set_min_1}   <= ms_step(set_min_10, set_min_1, up_pr);
          default:  {set_sec_10, set_sec_1}   <= ms_step(set_sec_10, set_sec_1, up_pr);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_watch_time_set.sv
// Directed bench for watch_time_set with a short debounce window.
module tb_watch_time_set;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw_in = '0;
  logic [3:0] sec_1 = '0, min_1 = '0, hour_1 = '0;
  logic [2:0] sec_10 = '0, min_10 = '0;
  logic [1:0] hour_10 = '0;
  logic [3:0] set_sec_1, set_min_1, set_hour_1;
  logic [2:0] set_sec_10, set_min_10;
  logic [1:0] set_hour_10;
  logic       load, run_en;
  logic [1:0] set_mode;

  int tests = 0;
  int fails = 0;
  int load_cnt = 0;
  int load_double = 0;
  logic load_prev = 1'b0;

  localparam logic [3:0] MODE = 4'b0001, UP = 4'b0010, DN = 4'b0100, CF = 4'b1000;

  watch_time_set #(.DEBOUNCE_CNT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in),
    .sec_1(sec_1), .sec_10(sec_10), .min_1(min_1), .min_10(min_10),
    .hour_1(hour_1), .hour_10(hour_10),
    .set_sec_1(set_sec_1), .set_sec_10(set_sec_10),
    .set_min_1(set_min_1), .set_min_10(set_min_10),
    .set_hour_1(set_hour_1), .set_hour_10(set_hour_10),
    .load(load), .run_en(run_en), .set_mode(set_mode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load) load_cnt++;
    if (load && load_prev) load_double++;
    load_prev = load;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] bits);
    @(negedge clk);
    sw_in = bits;
    repeat (6) @(posedge clk);
    @(negedge clk);
    sw_in = '0;
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_time(input string tag, input logic [23:0] exp);
    chk(tag, {2'b0, set_hour_10, set_hour_1, 1'b0, set_min_10, set_min_1,
              1'b0, set_sec_10, set_sec_1}, exp);
  endtask

  initial begin
    {hour_10, hour_1, min_10, min_1, sec_10, sec_1} = {2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mode", set_mode, 2'b00);
    chk("reset_run_en", run_en, 1'b1);
    chk("reset_load", load, 1'b0);
    chk_time("reset_time", 24'h000000);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 3-cycle glitch must be filtered out
    sw_in = MODE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sw_in = '0;
    repeat (12) @(negedge clk);
    chk("glitch_mode", set_mode, 2'b00);
    chk("glitch_run_en", run_en, 1'b1);

    press(MODE);
    chk("cap_mode", set_mode, 2'b01);
    chk("cap_run_en", run_en, 1'b0);
    chk_time("cap_time", 24'h123456);

    press(CF);
    chk("cf_hour_mode", set_mode, 2'b00);
    chk("cf_hour_run_en", run_en, 1'b1);
    chk("cf_hour_load", load_cnt, 1);
    chk_time("cf_hour_hold", 24'h123456);

    {hour_10, hour_1, min_10, min_1, sec_10, sec_1} = {2'd2, 4'd3, 3'd0, 4'd9, 3'd0, 4'd0};
    press(MODE);
    chk_time("cap2_time", 24'h230900);
    press(UP);
    chk_time("hour_up_wrap", 24'h000900);
    press(DN);
    chk_time("hour_dn_wrap", 24'h230900);
    press(UP | DN);
    chk_time("up_dn_same", 24'h230900);
    chk("up_dn_mode", set_mode, 2'b01);

    press(MODE);
    chk("mode_min", set_mode, 2'b10);
    chk("min_run_en", run_en, 1'b0);
    press(UP);
    chk_time("min_up_carry", 24'h231000);

    press(MODE);
    chk("mode_sec", set_mode, 2'b11);
    chk("sec_run_en", run_en, 1'b0);
    press(DN);
    chk_time("sec_dn_wrap", 24'h231059);
    press(UP);
    chk_time("sec_up_wrap", 24'h231000);
    press(DN);
    chk_time("sec_dn_again", 24'h231059);
    chk("no_load_in_edit", load_cnt, 1);

    press(MODE);
    chk("mode_run", set_mode, 2'b00);
    chk("mode_run_en", run_en, 1'b1);
    chk("mode_load", load_cnt, 2);
    chk_time("load_hold", 24'h231059);

    press(CF);
    chk("cf_run_load", load_cnt, 2);
    chk("cf_run_mode", set_mode, 2'b00);

    press(MODE);
    press(MODE);
    chk("pre_cfmode", set_mode, 2'b10);
    press(CF | MODE);
    chk("cfmode_mode", set_mode, 2'b00);
    chk("cfmode_load", load_cnt, 3);
    chk("cfmode_run_en", run_en, 1'b1);

    press(MODE);
    press(MODE);
    press(UP);
    chk("rst_pre_mode", set_mode, 2'b10);
    chk_time("rst_pre_time", 24'h231000);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_mode", set_mode, 2'b00);
    chk("async_run_en", run_en, 1'b1);
    chk("async_load", load, 1'b0);
    chk_time("async_time", 24'h000000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_load", load_cnt, 3);
    chk("post_rst_mode", set_mode, 2'b00);
    chk("load_one_cycle", load_double, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
